acc_col_serializer: RTL
=======================

Name: acc_col_serializer

Overview:
- Sits directly downstream of the processing engine.
- Accepts one wide beat holding COLS x ROWS accumulator words, then emits it column by column as COLS narrow beats of ROWS words each, in AXI-Stream fashion.
- A two-entry ping-pong buffer lets the next engine beat be accepted while the current one drains.
- Config beats are consumed and dropped; they produce no output.

Parameters:
- COLS, 8, columns per input beat (from `COLS).
- ROWS, 4, words per output beat (from `ROWS).
- WORD_WIDTH_ACC, 32, accumulator word width (from `WORD_WIDTH_ACC).
- TUSER_WIDTH, `TUSER_WIDTH, width of the tuser_st sideband.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- s_ready  out  1  buffer can accept a beat.
- s_valid  in  1  input beat valid.
- s_last  in  1  input beat is last of the packet.
- s_data  in  COLS*ROWS*WORD_WIDTH_ACC  packed [COLS-1:0][ROWS-1:0] accumulator words.
- s_user  in  tuser_st  sideband; is_config is used here.
- m_ready  in  1  downstream ready.
- m_valid  out  1  output beat valid.
- m_last  out  1  final column of a last input beat.
- m_data  out  ROWS*WORD_WIDTH_ACC  packed [ROWS-1:0] words of the current column.
- m_user  out  tuser_st  sideband of the entry being drained.
- m_col  out  $clog2(COLS)  index of the column on m_data.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. All state flops clear on resetn low; no synchronous reset terms.
- Storage: two entries, each holding data, user and last. Control state is wr_ptr (1b), rd_ptr (1b), count (0..2) and col (0..COLS-1).
- Reset values: count=0, wr_ptr=0, rd_ptr=0, col=0. Hence m_valid=0, m_last=0, m_col=0 and s_ready=1. Entry contents are don't-care; m_data and m_user may be X while m_valid=0.
- Accept:
  - Handshake s_valid && s_ready.
  - When s_user.is_config=0: write entry[wr_ptr], toggle wr_ptr, increment count.
  - When s_user.is_config=1: consume the beat, write nothing, leave count unchanged.
- s_ready = (count != 2). It depends only on registered state; no combinational path from m_ready to s_ready.
- Drain:
  - m_valid = (count != 0).
  - m_data = entry[rd_ptr].data[col].
  - m_user = entry[rd_ptr].user.
  - m_col = col.
  - m_last = entry[rd_ptr].last && (col == COLS-1).
- Column order: column 0 first, ascending.
- Advance on m_valid && m_ready:
  - If col < COLS-1: col++.
  - Otherwise: col=0, toggle rd_ptr, decrement count.
- Outputs hold stable while m_valid && !m_ready (AXI rule).
- Simultaneous accept and final-column pop in one cycle: count stays unchanged, both pointers toggle. With count=2 no accept is possible that cycle, because s_ready was 0. With count=1, the written slot is the free slot, never the one being read.
- Latency: a beat accepted on edge t shows its column 0 on m_valid in the cycle after edge t (one cycle), provided the buffer was empty.
- Throughput: with m_ready held high, exactly COLS output beats per data input beat and no bubbles between entries. Input stalls only when both entries are occupied.
- m_last propagates only through data beats. When s_last arrives on a config beat it is dropped.
- Reset mid-drain: everything clears immediately and asynchronously. Partially drained and pending entries are discarded. The first beat after release starts at col=0.

Test Plan:
1. Single data beat, m_ready=1, COLS=8, ROWS=4, word[c][r]=16*c+r, s_last=1.
   - Required: 8 beats, m_col 0..7 in consecutive cycles.
   - Beat c carries words 16c..16c+3.
   - m_last=1 only on m_col=7; m_valid first high one cycle after accept.
2. Back-to-back: three data beats presented continuously, m_ready=1.
   - Required: s_ready drops after the second accept and reasserts in the cycle after the pop of entry 0's column 7.
   - Output is 24 beats with no gaps, in input order.
3. Backpressure: m_ready toggles 1,0,0,1 repeating during a drain.
   - Required: m_data, m_col, m_user and m_last stay stable across stalled cycles.
   - No column skipped or duplicated; all 8 columns appear exactly once.
4. Config discard: sequence data(A), config(B, s_last=1), data(C, s_last=1).
   - Required: 16 output beats (A then C); B never appears.
   - m_last appears only on C's column 7; count never exceeds 2.
5. Simultaneous push/pop: count=1 at col=7 with m_ready=1 and s_valid=1 in the same cycle.
   - Required: count stays 1 and the new entry drains next from col 0.
   - The old entry's data is not corrupted during its column 7.
6. Reset mid-drain: assert resetn=0 asynchronously mid-cycle at col=3 with count=2.
   - Required: m_valid=0 and s_ready=1 without waiting for a clk edge.
   - After release, a new beat drains from m_col=0 with correct data.

Source files
------------

// File: rtl/acc_col_serializer.sv
// acc_col_serializer
// Takes one wide engine beat of COLS x ROWS accumulator words and replays it
// column by column as COLS narrow AXI-Stream beats. Two ping-pong entries let
// the next engine beat land while the current one drains. Config beats are
// swallowed without touching the buffer.

`ifndef COLS
`define COLS 8
`endif
`ifndef ROWS
`define ROWS 4
`endif
`ifndef WORD_WIDTH_ACC
`define WORD_WIDTH_ACC 32
`endif
`ifndef TUSER_WIDTH
`define TUSER_WIDTH 8
`endif

package acc_col_serializer_pkg;
   localparam int TUSER_WIDTH = `TUSER_WIDTH;

   // Sideband travelling with each engine beat; only is_config is interpreted.
   typedef struct packed {
      logic [TUSER_WIDTH-2:0] info;
      logic                   is_config;
   } tuser_st;
endpackage

// Handshake rules on both sides: a beat moves on a clock edge where valid and
// ready are both high. A source holds valid, data, user and last stable until
// that edge. s_ready is a pure function of registered occupancy, so nothing
// downstream (m_ready) reaches s_ready combinationally.
module acc_col_serializer
   import acc_col_serializer_pkg::*;
#(
   parameter int COLS           = `COLS,
   parameter int ROWS           = `ROWS,
   parameter int WORD_WIDTH_ACC = `WORD_WIDTH_ACC
) (
   input  logic                                          clk,
   input  logic                                          resetn,
   output logic                                          s_ready,
   input  logic                                          s_valid,
   input  logic                                          s_last,
   input  logic [COLS-1:0][ROWS-1:0][WORD_WIDTH_ACC-1:0] s_data,
   input  tuser_st                                       s_user,
   input  logic                                          m_ready,
   output logic                                          m_valid,
   output logic                                          m_last,
   output logic [ROWS-1:0][WORD_WIDTH_ACC-1:0]           m_data,
   output tuser_st                                       m_user,
   output logic [$clog2(COLS)-1:0]                       m_col
);

   localparam int            CW       = $clog2(COLS);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   // Ping-pong storage; contents are don't-care until written.
   logic [COLS-1:0][ROWS-1:0][WORD_WIDTH_ACC-1:0] r_data [2];
   tuser_st                                       r_user [2];
   logic                                          r_last [2];

   // Control state.
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;
   logic [CW-1:0] r_col;

   logic w_accept;
   logic w_write;
   logic w_advance;
   logic w_pop;

   assign s_ready   = (r_count != 2'd2);
   assign m_valid   = (r_count != 2'd0);

   assign w_accept  = s_valid && s_ready;
   // Config beats complete the handshake but never occupy an entry.
   assign w_write   = w_accept && !s_user.is_config;
   assign w_advance = m_valid && m_ready;
   // Final column leaving frees the entry being read.
   assign w_pop     = w_advance && (r_col == LAST_COL);

   assign m_data    = r_data[r_rd_ptr][r_col];
   assign m_user    = r_user[r_rd_ptr];
   assign m_col     = r_col;
   assign m_last    = r_last[r_rd_ptr] && (r_col == LAST_COL);

   // Capture an accepted data beat into the slot at the write pointer.
   // With one entry occupied this is always the free slot, so a push in the
   // same cycle as the last-column pop never disturbs the column on m_data.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_data[r_wr_ptr] <= s_data;
         r_user[r_wr_ptr] <= s_user;
         r_last[r_wr_ptr] <= s_last;
      end
   end

   // Pointers, occupancy and column counter; all cleared asynchronously so a
   // reset mid-drain discards both entries at once.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_col    <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= ~r_wr_ptr;
         end

         if (w_advance) begin
            if (r_col == LAST_COL) begin
               r_col    <= '0;
               r_rd_ptr <= ~r_rd_ptr;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
